// File: rtl/alu_seq.sv
// Registered eight-op ALU with auto/step/fixed/hold op sequencing and a
// valid/ready snapshot of each completed operation dwell.
module alu_seq #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned DWELL   = 100_000_000,
   parameter logic [7:0]  OP_MASK = 8'h3F
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [1:0]         mode,
   input  logic               step,
   input  logic [2:0]         op_sel,
   output logic [WIDTH-1:0]   y,
   output logic [3:0]         flags,
   output logic [2:0]         op,
   output logic               op_tick,
   output logic               snap_valid,
   input  logic               snap_ready,
   output logic [WIDTH+6:0]   snap_data,
   output logic               snap_ovf
);

   localparam int unsigned   CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

   typedef enum logic [2:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_ROL
   } op_e;

   typedef enum logic [1:0] {
      M_AUTO, M_STEP, M_FIXED, M_HOLD
   } mode_e;

   mode_e            mode_s;
   op_e              op_q, op_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             adv;
   logic [WIDTH:0]   sum, diff;
   logic [WIDTH-1:0] res;
   logic             c_flag, v_flag;
   logic [3:0]       flags_d;
   logic [2:0]       nxt, idx;
   logic             found;

   assign mode_s = mode_e'(mode);
   assign op     = op_q;

   always_comb begin
      sum    = {1'b0, a} + {1'b0, b};
      diff   = {1'b0, a} - {1'b0, b};
      res    = '0;
      c_flag = 1'b0;
      v_flag = 1'b0;
      case (op_q)
         OP_ADD: begin
            res    = sum[WIDTH-1:0];
            c_flag = sum[WIDTH];
            v_flag = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            res    = diff[WIDTH-1:0];
            c_flag = diff[WIDTH];
            v_flag = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         OP_XOR: res = a ^ b;
         OP_SHL: begin
            res    = {a[WIDTH-2:0], 1'b0};
            c_flag = a[WIDTH-1];
         end
         OP_SHR: begin
            res    = {1'b0, a[WIDTH-1:1]};
            c_flag = a[0];
         end
         OP_ROL: begin
            res    = {a[WIDTH-2:0], a[WIDTH-1]};
            c_flag = a[WIDTH-1];
         end
         default: res = '0;
      endcase
      flags_d = {c_flag, v_flag, res[WIDTH-1], (res == '0)};
   end

   // Scan forward from op+1; offset 8 wraps back to the current op itself.
   always_comb begin
      nxt   = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 1; i <= 8; i++) begin
         idx = op_q + 3'(i);
         if (!found && OP_MASK[idx]) begin
            nxt   = idx;
            found = 1'b1;
         end
      end
   end

   // Counter clears in every non-auto mode so re-entering auto starts a full dwell.
   always_comb begin
      cnt_d = '0;
      adv   = 1'b0;
      op_d  = op_q;
      case (mode_s)
         M_AUTO: begin
            if (cnt_q == CNT_LAST) begin
               adv  = 1'b1;
               op_d = op_e'(nxt);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         M_STEP: begin
            if (step) begin
               adv  = 1'b1;
               op_d = op_e'(nxt);
            end
         end
         M_FIXED: begin
            op_d = op_e'(op_sel);
            adv  = (op_sel != op_q);
         end
         M_HOLD:  op_d = op_q;
         default: op_d = op_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y          <= '0;
         flags      <= '0;
         op_q       <= OP_ADD;
         cnt_q      <= '0;
         op_tick    <= 1'b0;
         snap_valid <= 1'b0;
         snap_data  <= '0;
         snap_ovf   <= 1'b0;
      end else begin
         y       <= res;
         flags   <= flags_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         op_tick <= adv;
         if (adv && (!snap_valid || snap_ready)) begin
            snap_valid <= 1'b1;
            snap_data  <= {op_q, flags_d, res};
         end else if (adv) begin
            snap_ovf   <= 1'b1;
         end else if (snap_valid && snap_ready) begin
            snap_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor of the auto-cycling demo ALU. It is `WIDTH` bits wide, has eight operations and a programmable dwell time. A run-mode input selects auto-cycle, manual step, fixed-op or hold. Results carry status flags, and each completed operation dwell is captured into a valid/ready snapshot port for a downstream logger or display driver. It sits between the input pins and the output mux of the top-level wrapper.

## Interface
- `WIDTH`, 8: operand and result width; must be at least 2.
- `DWELL`, 100_000_000: cycles per operation in auto mode; must be at least 1. The counter width is `$clog2(DWELL)`, with a minimum of 1.
- `OP_MASK`, 8'h3F: bit k set means op k takes part in auto and step cycling.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `mode`  in  2  run mode: 00 auto, 01 step, 10 fixed, 11 hold.
- `step`  in  1  single-cycle advance request; only acted on in step mode.
- `op_sel`  in  3  operation used in fixed mode.
- `y`  out  WIDTH  registered result.
- `flags`  out  4  registered {C,V,N,Z}.
- `op`  out  3  current operation.
- `op_tick`  out  1  one-cycle pulse, high in the first cycle a new `op` is visible.
- `snap_valid`  out  1  snapshot available.
- `snap_ready`  in  1  downstream accepts the snapshot.
- `snap_data`  out  WIDTH+7  {op_prev[2:0], flags[3:0], y[WIDTH-1:0]} of the outgoing op.
- `snap_ovf`  out  1  sticky flag: a capture was dropped.

## Operation
- Ops:
  - 0: ADD, a+b.
  - 1: SUB, a-b.
  - 2: AND.
  - 3: OR.
  - 4: XOR.
  - 5: SHL, a<<1.
  - 6: SHR, a>>1 logical.
  - 7: ROL, a rotated left by 1.
  - All results are truncated to `WIDTH`.
- Flags:
  - C: carry out for ADD; borrow (a<b unsigned) for SUB; a[W-1] for SHL and ROL; a[0] for SHR; 0 for logic ops.
  - V: signed overflow for ADD/SUB, else 0.
  - N: y[W-1].
  - Z: y==0.
- Next-op rule: the next enabled op after the current one in `OP_MASK`, wrapping 7→0.
  - If `OP_MASK`==0, op stays 0.
  - If only the current op is enabled, op stays; `op_tick` still pulses.
- Auto mode:
  - The counter counts 0..DWELL-1.
  - At DWELL-1 the counter wraps to 0 and the op advances.
  - With DWELL=1 the op advances every cycle.
- Step mode:
  - The counter is held at 0.
  - Each cycle with `step`=1 advances the op, so a level held high advances every cycle.
- Fixed mode:
  - op <= `op_sel` every cycle, even if that op is masked out.
  - An advance (with `op_tick`) occurs only when `op_sel` differs from `op`.
- Hold mode: op and counter are frozen; `y` and `flags` keep tracking `a`/`b`.
- Leaving auto mode clears the counter, so re-entering auto starts a full dwell.
- Snapshot:
  - Captured on every advance as {outgoing op, its flags, its y}, using the value y/flags would take at that same edge.
  - If `snap_valid`=1 and not accepted in the capture cycle, the new capture is dropped, the old one is kept and `snap_ovf` is set.
  - If a capture and an accept coincide, the new snapshot replaces the old one and `snap_valid` stays 1 (no overflow).
  - `snap_ovf` clears only on reset.
- Reset, mid-operation included: `y`, `flags`, `op`, counter, `op_tick`, `snap_valid`, `snap_data` and `snap_ovf` all go to 0 immediately. The first cycle after release computes ADD.

## Timing
- `y`/`flags` are registered, with one-cycle latency from `a`, `b` and `op`.
- Op advance: the new `op` and `op_tick` appear after the advancing edge. `y` reflects the new op one edge later.
- `snap_valid` rises on the edge after the capture decision.
- A snapshot is accepted on an edge where `snap_valid`&&`snap_ready`. `snap_valid` then drops unless a simultaneous capture occurs.
- `snap_data` is stable while `snap_valid`=1 and not accepted.
- `op_tick` is never high in two consecutive cycles, except in step mode with `step` held high or DWELL=1.

## Test plan
- Reset and ADD: DWELL=4, W=8, a=8'hF0, b=8'h20, mode=auto. After reset release, the first y is 8'h10 with C=1, Z=0. The op then walks 0,1,2,3,4,5,0 with a new op every 4 cycles; `op_tick` is one cycle each time.
- SUB: a=8'h80, b=8'h01 gives y=8'h7F, V=1, C=0. a=8'h00, b=8'h01 gives y=8'hFF, C=1, N=1.
- Mask skip: OP_MASK=8'b1000_0101 in step mode with four `step` pulses gives op sequence 0→2→7→0→2. ROL of a=8'h81 gives 8'h03 with C=1.
- Fixed and hold: fixed with op_sel=6 and a=8'h01 gives y=8'h00, Z=1, C=1. Switching to hold and stepping/waiting 20 cycles keeps op=6 with no `op_tick`.
- Snapshot backpressure: with snap_ready=0 across two advances, the first snapshot is held and `snap_ovf`=1. Raising ready for 1 cycle gives one accept and `snap_valid`=0 the next cycle.
- Async reset mid-dwell: assert rst for half a cycle at counter=2, op=3. All outputs go to 0 immediately, with no clock edge needed.
